// File: rtl/demux_4x_nbit_reg.sv
// Registered 1-to-4 stream demultiplexer: one input stream steered by in_sel to
// four independent one-entry output registers, each with its own valid/ready.
module demux_4x_nbit_reg #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] a,
    output logic [BUS_WIDTH-1:0] b,
    output logic [BUS_WIDTH-1:0] c,
    output logic [BUS_WIDTH-1:0] d,
    output logic                 a_valid,
    output logic                 b_valid,
    output logic                 c_valid,
    output logic                 d_valid,
    input  logic                 a_ready,
    input  logic                 b_ready,
    input  logic                 c_ready,
    input  logic                 d_ready,
    output logic [3:0]           occupancy
);

    logic [BUS_WIDTH-1:0] data_q [4];
    logic [BUS_WIDTH-1:0] data_d [4];
    logic [3:0]           vld_q;
    logic [3:0]           vld_d;
    logic [3:0]           rdy;
    logic                 accept;

    assign rdy = {d_ready, c_ready, b_ready, a_ready};

    // A full channel can still take a word in the same cycle it drains.
    assign in_ready = !vld_q[in_sel] || rdy[in_sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
            vld_d[i]  = vld_q[i] && !rdy[i];
            if (accept && (in_sel == 2'(i))) begin
                data_d[i] = in_data;
                vld_d[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign a         = data_q[0];
    assign b         = data_q[1];
    assign c         = data_q[2];
    assign d         = data_q[3];
    assign a_valid   = vld_q[0];
    assign b_valid   = vld_q[1];
    assign c_valid   = vld_q[2];
    assign d_valid   = vld_q[3];
    assign occupancy = vld_q;

endmodule

// File: tb/tb_demux_4x_nbit_reg.sv
// Self-checking bench for demux_4x_nbit_reg: directed scenarios plus a randomized
// run against per-channel expected-word queues.
module tb_demux_4x_nbit_reg;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [1:0] in_sel = 2'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a, b, c, d;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_ready = 1'b0, b_ready = 1'b0, c_ready = 1'b0, d_ready = 1'b0;
    logic [3:0] occupancy;

    int checks = 0;
    int failures = 0;

    logic [7:0] dout [4];
    logic [3:0] vout;
    assign dout[0] = a;
    assign dout[1] = b;
    assign dout[2] = c;
    assign dout[3] = d;
    assign vout = {d_valid, c_valid, b_valid, a_valid};

    demux_4x_nbit_reg #(.BUS_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d),
        .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
        .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_readys(input logic [3:0] r);
        a_ready = r[0];
        b_ready = r[1];
        c_ready = r[2];
        d_ready = r[3];
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        set_readys(4'b0000);
        step();
        step();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 8'h5A;
        set_readys(4'b0000);
        for (int e = 0; e < 3; e++) begin
            step();
            checks++;
            if (occupancy !== 4'h0) begin
                failures++;
                $display("FAIL reset_occupancy: got %0h expected 0", occupancy);
            end
            for (int ch = 0; ch < 4; ch++) begin
                checks++;
                if (dout[ch] !== 8'h00) begin
                    failures++;
                    $display("FAIL reset_data ch%0d: got %0h expected 0", ch, dout[ch]);
                end
            end
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_ready sel%0d: got %0b expected 1", s, in_ready);
            end
        end
    endtask

    task automatic test_single_route();
        logic [7:0] w;
        set_readys(4'b0000);
        for (int s = 0; s < 4; s++) begin
            w        = 8'h11 * 8'(s + 1);
            in_sel   = 2'(s);
            in_data  = w;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            w = 8'h11 * 8'(s + 1);
            checks++;
            if (dout[s] !== w) begin
                failures++;
                $display("FAIL route_data ch%0d: got %0h expected %0h", s, dout[s], w);
            end
        end
        checks++;
        if (occupancy !== 4'hF) begin
            failures++;
            $display("FAIL route_occupancy: got %0h expected f", occupancy);
        end
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL route_full_in_ready sel%0d: got %0b expected 0", s, in_ready);
            end
        end
    endtask

    // Continues from the all-full state left by test_single_route.
    task automatic test_backpressure();
        in_sel   = 2'd1;
        in_data  = 8'h99;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || b !== 8'h22 || b_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_stall cyc%0d: got rdy=%0b b=%0h bv=%0b expected rdy=0 b=22 bv=1",
                         k, in_ready, b, b_valid);
            end
            step();
        end
        b_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_in_ready: got %0b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        b_ready  = 1'b0;
        checks++;
        if (b !== 8'h99 || b_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_reload: got b=%0h bv=%0b expected b=99 bv=1", b, b_valid);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        c_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_sel   = 2'd2;
            in_data  = 8'(i);
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL simul_in_ready word%0d: got %0b expected 1", i, in_ready);
            end
            step();
            checks++;
            if (c !== 8'(i) || c_valid !== 1'b1) begin
                failures++;
                $display("FAIL simul_data word%0d: got c=%0h cv=%0b expected c=%0h cv=1",
                         i, c, c_valid, i);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (c_valid !== 1'b0 || c !== 8'h08) begin
            failures++;
            $display("FAIL simul_tail: got c=%0h cv=%0b expected c=08 cv=0", c, c_valid);
        end
        c_ready = 1'b0;
    endtask

    task automatic test_independence();
        do_reset();
        in_sel   = 2'd0;
        in_data  = 8'h5C;
        in_valid = 1'b1;
        step();
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel  = 2'd3;
            in_data = 8'hA0 + 8'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL indep_in_ready word%0d: got %0b expected 1", i, in_ready);
            end
            step();
            checks++;
            if (d !== 8'hA0 + 8'(i) || d_valid !== 1'b1 || a !== 8'h5C || a_valid !== 1'b1) begin
                failures++;
                $display("FAIL indep_data word%0d: got d=%0h dv=%0b a=%0h av=%0b expected d=%0h dv=1 a=5c av=1",
                         i, d, d_valid, a, a_valid, 8'hA0 + 8'(i));
            end
        end
        in_valid = 1'b0;
        d_ready  = 1'b0;
    endtask

    task automatic test_async_reset_mid();
        do_reset();
        set_readys(4'b0000);
        in_sel   = 2'd0;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        in_sel  = 2'd2;
        in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (occupancy !== 4'h0 || a !== 8'h00 || c !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: got occ=%0h a=%0h c=%0h expected occ=0 a=0 c=0",
                     occupancy, a, c);
        end
        step();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        logic [7:0] mq [4][$];
        logic [7:0] prev_d [4];
        logic [3:0] prev_v;
        logic [3:0] r;
        logic       exp_rdy;
        logic       acc;
        int         sent [4];
        int         got  [4];
        do_reset();
        for (int ch = 0; ch < 4; ch++) begin
            mq[ch].delete();
            sent[ch] = 0;
            got[ch]  = 0;
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            r        = 4'($urandom_range(0, 15));
            set_readys(r);
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = 8'($urandom_range(0, 255));
            in_valid = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (mq[in_sel].size() == 0) || r[in_sel];
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rand_in_ready cyc%0d: got %0b expected %0b", cyc, in_ready, exp_rdy);
            end
            for (int ch = 0; ch < 4; ch++) begin
                checks++;
                if (vout[ch] !== (mq[ch].size() != 0) ||
                    (mq[ch].size() != 0 && dout[ch] !== mq[ch][0])) begin
                    failures++;
                    $display("FAIL rand_channel cyc%0d ch%0d: got v=%0b data=%0h expected v=%0b data=%0h",
                             cyc, ch, vout[ch], dout[ch], mq[ch].size() != 0,
                             (mq[ch].size() != 0) ? mq[ch][0] : 8'h00);
                end
                prev_d[ch] = dout[ch];
            end
            prev_v = vout;
            acc = in_valid && exp_rdy;
            @(posedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                if (mq[ch].size() != 0 && r[ch]) begin
                    void'(mq[ch].pop_front());
                    got[ch]++;
                end
            end
            if (acc) begin
                mq[in_sel].push_back(in_data);
                sent[in_sel]++;
            end
            #1;
            for (int ch = 0; ch < 4; ch++) begin
                if (prev_v[ch] && !r[ch]) begin
                    checks++;
                    if (vout[ch] !== 1'b1 || dout[ch] !== prev_d[ch]) begin
                        failures++;
                        $display("FAIL rand_stability cyc%0d ch%0d: got v=%0b data=%0h expected v=1 data=%0h",
                                 cyc, ch, vout[ch], dout[ch], prev_d[ch]);
                    end
                end
            end
        end
        set_readys(4'b0000);
        in_valid = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            checks++;
            if (sent[ch] != got[ch] + mq[ch].size() || mq[ch].size() > 1) begin
                failures++;
                $display("FAIL rand_conservation ch%0d: got sent=%0d drained=%0d pending=%0d expected sent=drained+pending, pending<=1",
                         ch, sent[ch], got[ch], mq[ch].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_backpressure();
        test_simultaneous();
        test_independence();
        test_async_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_4x_nbit_reg.md
# demux_4x_nbit_reg

Registered 1-to-4 stream demultiplexer, the inverse of the 4:1 n-bit mux: one n-bit input stream with a 2-bit select is steered to one of four output channels (a, b, c, d). Each channel has its own one-entry output register and a valid/ready handshake, so a stalled channel never blocks traffic to the other three. It sits between a single producer and four independent consumers.

## Interface
- BUS_WIDTH, 8, data width of the input and of every output channel.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  BUS_WIDTH  input word.
- in_sel  in  2  destination channel: 0=a, 1=b, 2=c, 3=d.
- in_valid  in  1  input word and sel valid.
- in_ready  out  1  demux accepts the input this cycle.
- a, b, c, d  out  BUS_WIDTH  registered channel data.
- a_valid, b_valid, c_valid, d_valid  out  1  channel register holds a word.
- a_ready, b_ready, c_ready, d_ready  in  1  channel consumer accepts the word.
- occupancy  out  4  {d_valid, c_valid, b_valid, a_valid}, for status/debug.

## Operation
- Per channel x: one register pair {x, x_valid}.
- Channel x drains on a cycle where x_valid=1 and x_ready=1.
- Input accept: in_valid=1 and in_ready=1.
- in_ready = !valid[in_sel] | ready[in_sel]. This is combinational from in_sel and the selected channel's valid/ready. It is evaluated even when in_valid=0.
- On accept, the selected channel loads in_data and its valid is set to 1.
- Channel x with no accept and a drain: x_valid clears to 0, and x keeps its last value.
- Channel x with both accept and drain in the same cycle: x loads the new word and x_valid stays 1. There is no bubble, so back-to-back throughput is 1 word/cycle per channel.
- Channel x with neither: it holds.
- Only the selected channel can load. The other channels drain independently in the same cycle.
- in_sel and in_data are ignored when in_valid=0.
- No word is ever dropped or duplicated. Order within a channel is preserved.
- Once x_valid=1, x and x_valid must not change until the word drains (AXI-style stability).
- Consumers may assert x_ready at any time, including while x_valid=0. This has no effect.
- There is no FSM beyond the per-channel EMPTY/FULL bit:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or on no drain.

## Timing
- Reset (reset_n low, asynchronous): all x_valid=0, all x=0, occupancy=0.
  - in_ready then reads 1 for any in_sel, because every channel is empty.
- Reset asserted mid-operation discards all held words immediately, without waiting for a clock edge.
- Latency: a word accepted at rising edge k appears on x with x_valid=1 immediately after edge k. It can drain at edge k+1 at the earliest.
- in_ready has a combinational path from x_ready. There is no combinational path from in_data to any output.
- occupancy follows the valid registers directly and has no extra latency.

## Test plan
- Reset: hold reset_n=0 with in_valid=1, in_sel=2, in_data=8'h5A, and clock 3 edges.
  - Expect occupancy=0 and a..d=0 throughout.
  - Release reset: in_ready=1.
- Single route: all readys=0. Send 8'h11 to sel=0, 8'h22 to sel=1, 8'h33 to sel=2, 8'h44 to sel=3 on 4 consecutive edges.
  - Expect a=11, b=22, c=33, d=44 and occupancy=4'hF.
  - in_ready=0 for every sel.
- Backpressure: with channel b full (8'h22) and b_ready=0, present sel=1, data=8'h99 for 5 cycles.
  - Expect in_ready=0 throughout and b stable at 22.
  - Raise b_ready: at that edge, 22 drains and 99 loads, and b_valid stays 1.
- Simultaneous load and drain: c_ready=1 constant, stream 8'h01..8'h08 to sel=2 on 8 consecutive edges.
  - Expect in_ready=1 every cycle.
  - c shows 01..08 on consecutive cycles.
  - c_valid deasserts one cycle after the last accept.
- Independence: channel a full with a_ready=0; stream 8'hA0..8'hA3 to sel=3 with d_ready=1.
  - Expect all four accepted with no stall and a unchanged.
- Randomized: 200 cycles of random sel, data, valid, and readys, checked against a per-channel scoreboard queue.
  - Expect no loss, no duplication, in-order delivery, and the stability rule never violated.
